// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types and constants
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    ERR
  } fetch_state_e;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_TGT  = 2'b01,
    PCSRC_JALR = 2'b10,
    PCSRC_ILL  = 2'b11
  } pcsrc_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC mux with illegal-select and misalignment detection
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] pc_target_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] next_pc_o,
  output logic        illegal_o,
  output logic        misaligned_o
);

  always_comb begin
    next_pc_o = pc_i + 32'd4;
    illegal_o = 1'b0;
    case (pcsrc_i)
      PCSRC_SEQ:  next_pc_o = pc_i + 32'd4;
      PCSRC_TGT:  next_pc_o = pc_target_i;
      PCSRC_JALR: next_pc_o = alu_result_i & 32'hFFFF_FFFE;
      default: begin
        next_pc_o = pc_i;
        illegal_o = 1'b1;
      end
    endcase
  end

  // Alignment only matters for a legal select; an illegal one already faults.
  assign misaligned_o = !illegal_o && (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32 fetch stage: PC register, one-outstanding imem request, held instruction
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  output logic        fetch_err
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  instr_q;
  logic         req_q;
  logic         valid_q;
  logic         err_q;
  logic         illegal;
  logic         misaligned;

  pc_next_sel u_pc_next_sel (
    .pc_i         (pc_q),
    .pcsrc_i      (PCSrc),
    .pc_target_i  (PCTarget),
    .alu_result_i (ALUResult),
    .next_pc_o    (pc_d),
    .illegal_o    (illegal),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          if (imem_gnt) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_q <= HOLD;
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            valid_q <= 1'b0;
            // A faulting redirect leaves pc_q on the instruction that caused it.
            if (illegal || misaligned) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= REQ;
              pc_q    <= pc_d;
              req_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ERR;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_err   = err_q;

endmodule
